// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile
// I2C target with a local file of REG_COUNT 32-bit registers. It decodes
// frames of the form START, {dev_addr, r/w}, reg_addr, four data bytes
// (MSB byte first). Writes update the register file and raise a one-cycle
// host strobe. Reads return the addressed word to the master.
//
// Ports:
//   clk, rst                : system clock, async active-low reset
//   scl, sda_in             : serial clock/data from the master (oversampled)
//   sda_out                 : serial data to the master, 1 = released
//   busy                    : high between detected START and STOP/abort
//   wr_strobe/wr_addr/wr_data : one-cycle notification of a completed write
//   host_rd_addr/host_rd_data : combinational host read port (0 out of range)
//
// Optional feature: define I2C_SLAVE_AUTOINC_EN to let one transaction carry
// several words, with the register address incrementing (and wrapping to 0
// at REG_COUNT) after each completed word.
module i2c_slave_regfile #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h50,
    parameter int unsigned REG_COUNT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl,
    input  logic        sda_in,
    output logic        sda_out,
    output logic        busy,
    output logic        wr_strobe,
    output logic [7:0]  wr_addr,
    output logic [31:0] wr_data,
    input  logic [7:0]  host_rd_addr,
    output logic [31:0] host_rd_data
);

    localparam int unsigned DW = 32;
    localparam int unsigned AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        DEV_ADDR  = 4'd1,
        DEV_ACK   = 4'd2,
        REG_ADDR  = 4'd3,
        REG_ACK   = 4'd4,
        WR_DATA   = 4'd5,
        WR_ACK    = 4'd6,
        RD_DATA   = 4'd7,
        RD_ACK    = 4'd8,
        WAIT_STOP = 4'd9
    } state_t;

    state_t state, state_nxt;

    // Synchronizer chains; the third flop of each gives the previous value
    // for edge detection.
    logic scl_s1, scl_s2, scl_d;
    logic sda_s1, sda_s2, sda_d;

    // Datapath registers and their next values
    logic          bit_cnt_en_unused;
    logic [3:0]    bit_cnt,  bit_cnt_nxt;
    logic [7:0]    shreg,    shreg_nxt;
    logic [1:0]    byte_cnt, byte_cnt_nxt;
    logic          rw,       rw_nxt;
    logic          nack,     nack_nxt;
    logic [7:0]    reg_addr, reg_addr_nxt;
    logic [DW-1:0] data_sr,  data_sr_nxt;
    logic          sda_out_nxt, busy_nxt, wr_strobe_nxt;
    logic [7:0]    wr_addr_nxt;
    logic [DW-1:0] wr_data_nxt;

    logic [DW-1:0] regs [REG_COUNT];

    logic          scl_rise_c, scl_fall_c, start_c, stop_c;
    logic          byte_done_c, dev_match_c, reg_ok_c, last_byte_c;
    logic [7:0]    shreg_in_c;
    logic [DW-1:0] cur_word_c;
    logic          reg_we_c;
    logic          host_in_range_c;

    assign bit_cnt_en_unused = 1'b0;

    // Input synchronizers, idle-high reset so no false START after reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= scl;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= sda_in;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    // Bus events on the synchronized copies
    assign scl_rise_c  = scl_s2 & ~scl_d;
    assign scl_fall_c  = ~scl_s2 & scl_d;
    assign start_c     = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_c      = scl_s2 & scl_d & ~sda_d & sda_s2;

    assign byte_done_c = (bit_cnt == 4'd8);
    assign shreg_in_c  = {shreg[6:0], sda_s2};
    assign dev_match_c = (shreg[7:1] == SLAVE_ADDR);
    assign reg_ok_c    = ({1'b0, shreg} < 9'(REG_COUNT));
    assign last_byte_c = (byte_cnt == 2'd3);
    assign cur_word_c  = regs[reg_addr[AW-1:0]];

`ifdef I2C_SLAVE_AUTOINC_EN
    logic [7:0]    next_addr_c;
    logic [DW-1:0] next_word_c;

    // Register address after a completed word, wrapping at REG_COUNT
    assign next_addr_c = ((9'(reg_addr) + 9'd1) == 9'(REG_COUNT)) ? 8'd0
                                                                   : reg_addr + 8'd1;
    assign next_word_c = regs[next_addr_c[AW-1:0]];
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; START/STOP override every state
    always_comb begin
        state_nxt = state;
        if (start_c) begin
            state_nxt = DEV_ADDR;
        end else if (stop_c) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                DEV_ADDR: if (scl_fall_c && byte_done_c)
                              state_nxt = dev_match_c ? DEV_ACK : WAIT_STOP;
                DEV_ACK:  if (scl_fall_c) state_nxt = REG_ADDR;
                REG_ADDR: if (scl_fall_c && byte_done_c)
                              state_nxt = reg_ok_c ? REG_ACK : WAIT_STOP;
                REG_ACK:  if (scl_fall_c) state_nxt = rw ? RD_DATA : WR_DATA;
                WR_DATA:  if (scl_fall_c && byte_done_c) state_nxt = WR_ACK;
                WR_ACK: begin
                    if (scl_fall_c) begin
`ifdef I2C_SLAVE_AUTOINC_EN
                        state_nxt = WR_DATA;
`else
                        state_nxt = last_byte_c ? WAIT_STOP : WR_DATA;
`endif
                    end
                end
                RD_DATA:  if (scl_fall_c && byte_done_c) state_nxt = RD_ACK;
                RD_ACK: begin
                    if (scl_fall_c) begin
                        if (nack) begin
                            state_nxt = WAIT_STOP;
                        end else begin
`ifdef I2C_SLAVE_AUTOINC_EN
                            state_nxt = RD_DATA;
`else
                            state_nxt = last_byte_c ? WAIT_STOP : RD_DATA;
`endif
                        end
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Output and datapath next values. sda_out only moves on scl falling
    // edges (or START/STOP) so it is stable across every scl high phase.
    always_comb begin
        sda_out_nxt   = sda_out;
        busy_nxt      = busy;
        wr_strobe_nxt = 1'b0;
        wr_addr_nxt   = wr_addr;
        wr_data_nxt   = wr_data;
        bit_cnt_nxt   = bit_cnt;
        shreg_nxt     = shreg;
        byte_cnt_nxt  = byte_cnt;
        rw_nxt        = rw;
        nack_nxt      = nack;
        reg_addr_nxt  = reg_addr;
        data_sr_nxt   = data_sr;
        reg_we_c      = 1'b0;

        if (start_c) begin
            busy_nxt     = 1'b1;
            sda_out_nxt  = 1'b1;
            bit_cnt_nxt  = 4'd0;
            byte_cnt_nxt = 2'd0;
        end else if (stop_c) begin
            busy_nxt     = 1'b0;
            sda_out_nxt  = 1'b1;
            bit_cnt_nxt  = 4'd0;
            byte_cnt_nxt = 2'd0;
        end else begin
            case (state)
                DEV_ADDR: begin
                    if (scl_rise_c) begin
                        shreg_nxt   = shreg_in_c;
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end else if (scl_fall_c && byte_done_c) begin
                        rw_nxt      = shreg[0];
                        bit_cnt_nxt = 4'd0;
                        sda_out_nxt = ~dev_match_c;
                    end
                end
                DEV_ACK: begin
                    if (scl_fall_c) begin
                        sda_out_nxt = 1'b1;
                        bit_cnt_nxt = 4'd0;
                    end
                end
                REG_ADDR: begin
                    if (scl_rise_c) begin
                        shreg_nxt   = shreg_in_c;
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end else if (scl_fall_c && byte_done_c) begin
                        bit_cnt_nxt = 4'd0;
                        sda_out_nxt = ~reg_ok_c;
                        if (reg_ok_c) reg_addr_nxt = shreg;
                    end
                end
                REG_ACK: begin
                    if (scl_fall_c) begin
                        bit_cnt_nxt  = 4'd0;
                        byte_cnt_nxt = 2'd0;
                        if (rw) begin
                            // Latch the word and present its MSB immediately
                            sda_out_nxt = cur_word_c[DW-1];
                            data_sr_nxt = {cur_word_c[DW-2:0], 1'b0};
                        end else begin
                            sda_out_nxt = 1'b1;
                        end
                    end
                end
                WR_DATA: begin
                    if (scl_rise_c) begin
                        shreg_nxt   = shreg_in_c;
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end else if (scl_fall_c && byte_done_c) begin
                        bit_cnt_nxt = 4'd0;
                        sda_out_nxt = 1'b0;
                        data_sr_nxt = {data_sr[DW-9:0], shreg};
                    end
                end
                WR_ACK: begin
                    if (scl_fall_c) begin
                        sda_out_nxt = 1'b1;
                        bit_cnt_nxt = 4'd0;
                        if (last_byte_c) begin
                            // Word complete only once its last ACK bit ends
                            reg_we_c      = 1'b1;
                            wr_strobe_nxt = 1'b1;
                            wr_addr_nxt   = reg_addr;
                            wr_data_nxt   = data_sr;
                            byte_cnt_nxt  = 2'd0;
`ifdef I2C_SLAVE_AUTOINC_EN
                            reg_addr_nxt  = next_addr_c;
`endif
                        end else begin
                            byte_cnt_nxt = byte_cnt + 2'd1;
                        end
                    end
                end
                RD_DATA: begin
                    if (scl_rise_c) begin
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end else if (scl_fall_c) begin
                        if (byte_done_c) begin
                            // Release for the master's ACK bit
                            bit_cnt_nxt = 4'd0;
                            sda_out_nxt = 1'b1;
                        end else begin
                            sda_out_nxt = data_sr[DW-1];
                            data_sr_nxt = {data_sr[DW-2:0], 1'b0};
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise_c) begin
                        nack_nxt = sda_s2;
                    end else if (scl_fall_c) begin
                        bit_cnt_nxt = 4'd0;
                        if (nack) begin
                            sda_out_nxt = 1'b1;
                        end else if (last_byte_c) begin
`ifdef I2C_SLAVE_AUTOINC_EN
                            reg_addr_nxt = next_addr_c;
                            byte_cnt_nxt = 2'd0;
                            sda_out_nxt  = next_word_c[DW-1];
                            data_sr_nxt  = {next_word_c[DW-2:0], 1'b0};
`else
                            sda_out_nxt  = 1'b1;
`endif
                        end else begin
                            byte_cnt_nxt = byte_cnt + 2'd1;
                            sda_out_nxt  = data_sr[DW-1];
                            data_sr_nxt  = {data_sr[DW-2:0], 1'b0};
                        end
                    end
                end
                WAIT_STOP: sda_out_nxt = 1'b1;
                default:   sda_out_nxt = 1'b1;
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sda_out   <= 1'b1;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            byte_cnt  <= '0;
            rw        <= 1'b0;
            nack      <= 1'b0;
            reg_addr  <= '0;
            data_sr   <= '0;
        end else begin
            sda_out   <= sda_out_nxt;
            busy      <= busy_nxt;
            wr_strobe <= wr_strobe_nxt;
            wr_addr   <= wr_addr_nxt;
            wr_data   <= wr_data_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shreg     <= shreg_nxt;
            byte_cnt  <= byte_cnt_nxt;
            rw        <= rw_nxt;
            nack      <= nack_nxt;
            reg_addr  <= reg_addr_nxt;
            data_sr   <= data_sr_nxt;
        end
    end

    // Register file; written in the same cycle wr_strobe is registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(REG_COUNT); i++) begin
                regs[i] <= '0;
            end
        end else if (reg_we_c) begin
            regs[reg_addr[AW-1:0]] <= data_sr;
        end
    end

    // Host read port: old value until the write edge, new value after
    assign host_in_range_c = ({1'b0, host_rd_addr} < 9'(REG_COUNT));
    assign host_rd_data    = host_in_range_c ? regs[host_rd_addr[AW-1:0]] : '0;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: the bench acts as the I2C master and checks
// ACK/NACK bits, read data, write strobes, busy and the host read port.
module tb_i2c_slave_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        scl;
    logic        sda_in;
    logic        sda_out;
    logic        busy;
    logic        wr_strobe;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [7:0]  host_rd_addr;
    logic [31:0] host_rd_data;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  strobe_addr_q [$];
    logic [31:0] strobe_data_q [$];
    bit          watch_low = 1'b0;
    bit          low_seen  = 1'b0;

    typedef struct {
        logic        rw;
        logic [6:0]  dev;
        logic [7:0]  ra;
        logic [31:0] data;        // write data, or expected read word
        int          nbytes;
        logic        exp_dev_ack;
        logic        exp_reg_ack;
        int          exp_strobes;
        logic [31:0] exp_host;    // host_rd_data at ra after the transaction
    } vec_t;

    vec_t vecs [11];

    always #5 clk = ~clk;

    i2c_slave_regfile #(.SLAVE_ADDR(7'h50), .REG_COUNT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .scl          (scl),
        .sda_in       (sda_in),
        .sda_out      (sda_out),
        .busy         (busy),
        .wr_strobe    (wr_strobe),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .host_rd_addr (host_rd_addr),
        .host_rd_data (host_rd_data)
    );

    // Record every strobe cycle; a stretched pulse shows up as extra entries
    always @(negedge clk) begin
        if (wr_strobe) begin
            strobe_addr_q.push_back(wr_addr);
            strobe_data_q.push_back(wr_data);
        end
        if (watch_low && !sda_out) low_seen = 1'b1;
    end

    initial begin
        #900us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_in = 1'b1; wait_clk(4);
        scl    = 1'b1; wait_clk(4);
        sda_in = 1'b0; wait_clk(4);
        scl    = 1'b0; wait_clk(4);
    endtask

    task automatic i2c_stop();
        sda_in = 1'b0; wait_clk(4);
        scl    = 1'b1; wait_clk(4);
        sda_in = 1'b1; wait_clk(8);
    endtask

    // One scl period: data set while low, slave sampled mid-high
    task automatic clock_bit(input logic b, output logic r);
        sda_in = b;  wait_clk(4);
        scl = 1'b1;  wait_clk(4);
        r = sda_out; wait_clk(4);
        scl = 1'b0;  wait_clk(4);
    endtask

    // Returns the slave's ACK bit (0 = ACK)
    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], r);
        clock_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, r);
            b[i] = r;
        end
        clock_bit(mack, r);
    endtask

    task automatic host_check(input string name, input logic [7:0] a, input logic [31:0] exp);
        host_rd_addr = a;
        wait_clk(1);
        check(name, host_rd_data, exp);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          s0;
        logic        ack;
        logic [7:0]  b;
        logic [31:0] w;
        s0 = strobe_addr_q.size();
        low_seen  = 1'b0;
        watch_low = 1'b1;
        i2c_start();
        check($sformatf("v%0d busy_after_start", idx), 32'(busy), 32'd1);
        write_byte({v.dev, v.rw}, ack);
        check($sformatf("v%0d dev_ack", idx), 32'(ack), 32'(!v.exp_dev_ack));
        if (v.exp_dev_ack) begin
            write_byte(v.ra, ack);
            check($sformatf("v%0d reg_ack", idx), 32'(ack), 32'(!v.exp_reg_ack));
            if (v.exp_reg_ack) begin
                if (!v.rw) begin
                    for (int i = 0; i < v.nbytes; i++) begin
                        write_byte(8'(v.data >> (24 - 8 * i)), ack);
                        check($sformatf("v%0d data_ack%0d", idx, i), 32'(ack), 32'd0);
                    end
                end else begin
                    w = '0;
                    for (int i = 0; i < 4; i++) begin
                        read_byte(logic'(i == 3), b);
                        w = {w[23:0], b};
                    end
                    check($sformatf("v%0d rd_word", idx), w, v.data);
                end
            end
        end
        i2c_stop();
        watch_low = 1'b0;
        if (!v.exp_dev_ack) check($sformatf("v%0d sda_low_seen", idx), 32'(low_seen), 32'd0);
        check($sformatf("v%0d busy_after_stop", idx), 32'(busy), 32'd0);
        check($sformatf("v%0d strobes", idx), 32'(strobe_addr_q.size() - s0), 32'(v.exp_strobes));
        if (v.exp_strobes == 1 && strobe_addr_q.size() > s0) begin
            check($sformatf("v%0d wr_addr", idx), 32'(strobe_addr_q[s0]), 32'(v.ra));
            check($sformatf("v%0d wr_data", idx), strobe_data_q[s0], v.data);
        end
        host_check($sformatf("v%0d host_rd", idx), v.ra, v.exp_host);
    endtask

    initial begin
        int          s0;
        logic        ack;
        logic        r;
        logic [7:0]  b;
        logic [7:0]  acks;
        vec_t        v;

        //          rw    dev    ra     data          n  dack  rack  strb host
        vecs[0]  = '{1'b0, 7'h50, 8'h03, 32'hDEADBEEF, 4, 1'b1, 1'b1, 1, 32'hDEADBEEF};
        vecs[1]  = '{1'b1, 7'h50, 8'h03, 32'hDEADBEEF, 4, 1'b1, 1'b1, 0, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 7'h51, 8'h03, 32'h0BADF00D, 4, 1'b0, 1'b0, 0, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 7'h50, 8'h10, 32'h0BADF00D, 4, 1'b1, 1'b0, 0, 32'h00000000};
        vecs[4]  = '{1'b0, 7'h50, 8'h05, 32'hCAFEF00D, 2, 1'b1, 1'b1, 0, 32'h00000000};
        vecs[5]  = '{1'b0, 7'h50, 8'h05, 32'h12345678, 4, 1'b1, 1'b1, 1, 32'h12345678};
        vecs[6]  = '{1'b1, 7'h50, 8'h05, 32'h12345678, 4, 1'b1, 1'b1, 0, 32'h12345678};
        vecs[7]  = '{1'b1, 7'h50, 8'h00, 32'h00000000, 4, 1'b1, 1'b1, 0, 32'h00000000};
        vecs[8]  = '{1'b0, 7'h50, 8'h0F, 32'hA5A50F0F, 4, 1'b1, 1'b1, 1, 32'hA5A50F0F};
        vecs[9]  = '{1'b1, 7'h50, 8'h0F, 32'hA5A50F0F, 4, 1'b1, 1'b1, 0, 32'hA5A50F0F};
        vecs[10] = '{1'b1, 7'h50, 8'hFF, 32'h00000000, 4, 1'b1, 1'b0, 0, 32'h00000000};

        rst = 1'b0;
        scl = 1'b1;
        sda_in = 1'b1;
        host_rd_addr = 8'h03;
        wait_clk(3);
        check("rst_sda_out",   32'(sda_out),   32'd1);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
        check("rst_wr_addr",   32'(wr_addr),   32'd0);
        check("rst_wr_data",   wr_data,        32'd0);
        check("rst_host_rd",   host_rd_data,   32'd0);
        rst = 1'b1;
        wait_clk(4);

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // Repeated START after two write bytes discards the partial word
        s0 = strobe_addr_q.size();
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h07, ack);
        write_byte(8'hAA, ack);
        write_byte(8'hBB, ack);
        i2c_start();
        check("rs_busy", 32'(busy), 32'd1);
        write_byte(8'hA0, ack);
        check("rs_dev_ack", 32'(ack), 32'd0);
        write_byte(8'h07, ack);
        write_byte(8'h01, ack);
        write_byte(8'h02, ack);
        write_byte(8'h03, ack);
        write_byte(8'h04, ack);
        check("rs_last_ack", 32'(ack), 32'd0);
        i2c_stop();
        check("rs_strobes", 32'(strobe_addr_q.size() - s0), 32'd1);
        host_check("rs_host_rd7", 8'h07, 32'h01020304);

        // Master NACKs the first read byte: slave must release afterwards
        i2c_start();
        write_byte(8'hA1, ack);
        write_byte(8'h03, ack);
        read_byte(1'b1, b);
        check("nk_byte0", 32'(b), 32'hDE);
        read_byte(1'b1, b);
        check("nk_released", 32'(b), 32'hFF);
        i2c_stop();
        check("nk_busy", 32'(busy), 32'd0);

        // Two words to the last register: wrap with auto-increment, or a
        // NACKed fifth byte without it
        s0 = strobe_addr_q.size();
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h0F, ack);
        for (int i = 0; i < 8; i++) begin
            write_byte((i < 4) ? 8'h11 : 8'h22, ack);
            acks[i] = ack;
        end
        i2c_stop();
`ifdef I2C_SLAVE_AUTOINC_EN
        check("ai_acks", 32'(acks), 32'h00);
        check("ai_strobes", 32'(strobe_addr_q.size() - s0), 32'd2);
        if (strobe_addr_q.size() > s0 + 1) begin
            check("ai_addr0", 32'(strobe_addr_q[s0]),     32'h0F);
            check("ai_addr1", 32'(strobe_addr_q[s0 + 1]), 32'h00);
            check("ai_data1", strobe_data_q[s0 + 1], 32'h22222222);
        end
        host_check("ai_host0", 8'h00, 32'h22222222);
`else
        check("ai_acks", 32'(acks), 32'hF0);
        check("ai_strobes", 32'(strobe_addr_q.size() - s0), 32'd1);
        if (strobe_addr_q.size() > s0) begin
            check("ai_addr0", 32'(strobe_addr_q[s0]), 32'h0F);
        end
        host_check("ai_host0", 8'h00, 32'h00000000);
`endif
        host_check("ai_host15", 8'h0F, 32'h11111111);

        // Reset while the slave is driving an ACK
        i2c_start();
        b = 8'hA0;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], r);
        sda_in = 1'b1; wait_clk(4);
        scl = 1'b1;    wait_clk(2);
        check("mr_ack_driven", 32'(sda_out), 32'd0);
        host_rd_addr = 8'h03;
        #1 rst = 1'b0;
        #1;
        check("mr_sda_out", 32'(sda_out),   32'd1);
        check("mr_busy",    32'(busy),      32'd0);
        check("mr_wr_addr", 32'(wr_addr),   32'd0);
        check("mr_wr_data", wr_data,        32'd0);
        check("mr_regs",    host_rd_data,   32'd0);
        wait_clk(2);
        rst = 1'b1;
        wait_clk(4);
        scl = 1'b0;
        wait_clk(4);

        // Clocking without a START must be ignored
        for (int i = 7; i >= 0; i--) clock_bit(b[i], r);
        clock_bit(1'b1, r);
        check("ns_no_ack", 32'(r),    32'd1);
        check("ns_busy",   32'(busy), 32'd0);
        i2c_stop();

        v = '{1'b0, 7'h50, 8'h02, 32'h55AA55AA, 4, 1'b1, 1'b1, 1, 32'h55AA55AA};
        run_vec(11, v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
